// File: rtl/fb_arb_pkg.sv
// Shared types and constants for the framebuffer arbiter.
// The FB_ARB_STATS_EN build option is described in framebuffer_arbiter.sv.
package fb_arb_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      CPU_ACK = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_VGA  = 2'd1,
      OWN_CPU  = 2'd2
   } owner_t;

   localparam int CPU_MAX_WAIT_DEFAULT = 8;
   localparam int WAIT_CNT_WIDTH       = 8;
   localparam int STAT_WIDTH           = 32;

endpackage

// File: rtl/framebuffer_arbiter_if.sv
// Bundles the VGA fetch, CPU bus and framebuffer memory signals around the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface framebuffer_arbiter_if #(
   parameter int ADDR_WIDTH = 17,
   parameter int DATA_WIDTH = 32
);

   logic                      vga_req;
   logic [ADDR_WIDTH-1:0]     vga_addr;
   logic                      vga_gnt;
   logic                      vga_rvalid;
   logic [DATA_WIDTH-1:0]     vga_rdata;

   logic                      cpu_req;
   logic                      cpu_we;
   logic [ADDR_WIDTH-1:0]     cpu_addr;
   logic [DATA_WIDTH-1:0]     cpu_wdata;
   logic [DATA_WIDTH/8-1:0]   cpu_wstrb;
   logic                      cpu_ack;
   logic [DATA_WIDTH-1:0]     cpu_rdata;

   logic                      mem_en;
   logic [DATA_WIDTH/8-1:0]   mem_we;
   logic [ADDR_WIDTH-1:0]     mem_addr;
   logic [DATA_WIDTH-1:0]     mem_wdata;
   logic [DATA_WIDTH-1:0]     mem_rdata;

   modport slave (
      input  vga_req, vga_addr,
      output vga_gnt, vga_rvalid, vga_rdata,
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
      output cpu_ack, cpu_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output vga_req, vga_addr,
      input  vga_gnt, vga_rvalid, vga_rdata,
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
      input  cpu_ack, cpu_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/fb_arb_stats.sv
// Free-running 32-bit wrapping counters of VGA grants and CPU blocked cycles.
// Only instantiated when FB_ARB_STATS_EN is defined.
module fb_arb_stats
   import fb_arb_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_vgaGnt,
   input  logic                  i_cpuStall,
   output logic [STAT_WIDTH-1:0] o_vgaCnt,
   output logic [STAT_WIDTH-1:0] o_cpuStallCnt
);

   logic [STAT_WIDTH-1:0] r_vgaCnt;
   logic [STAT_WIDTH-1:0] r_cpuStallCnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vgaCnt      <= '0;
         r_cpuStallCnt <= '0;
      end else begin
         if (i_vgaGnt) begin
            r_vgaCnt <= r_vgaCnt + 1'b1;
         end
         if (i_cpuStall) begin
            r_cpuStallCnt <= r_cpuStallCnt + 1'b1;
         end
      end
   end

   assign o_vgaCnt      = r_vgaCnt;
   assign o_cpuStallCnt = r_cpuStallCnt;

endmodule

// File: rtl/framebuffer_arbiter.sv
// Single-port framebuffer BRAM arbiter: VGA scanout has priority, CPU is starvation-protected.
// Define FB_ARB_STATS_EN to build the grant/stall statistics counters.
module framebuffer_arbiter
   import fb_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 17,
   parameter int DATA_WIDTH   = 32,
   parameter int CPU_MAX_WAIT = CPU_MAX_WAIT_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   framebuffer_arbiter_if.slave     bus,
   output logic [STAT_WIDTH-1:0]    stat_vga_cnt,
   output logic [STAT_WIDTH-1:0]    stat_cpu_stall_cnt
);

   localparam int                        STRB_WIDTH = DATA_WIDTH / 8;
   localparam logic [WAIT_CNT_WIDTH-1:0] MAX_WAIT   = WAIT_CNT_WIDTH'(CPU_MAX_WAIT);

   state_t                    r_state;
   state_t                    w_nextState;
   owner_t                    w_owner;
   logic [WAIT_CNT_WIDTH-1:0] r_waitCnt;

   logic                      w_cpuStarved;
   logic                      w_cpuGnt;
   logic                      w_vgaGnt;
   logic                      w_cpuStall;

   logic                      r_vgaRvalid;
   logic                      r_cpuAck;
   logic                      r_cpuRead;

   logic                      w_memEn;
   logic [STRB_WIDTH-1:0]     w_memWe;
   logic [ADDR_WIDTH-1:0]     w_memAddr;
   logic [DATA_WIDTH-1:0]     w_memWdata;

   assign w_cpuStarved = bus.cpu_req && (r_state == IDLE) && (r_waitCnt == MAX_WAIT);

   // Arbitration and next state; CPU_ACK always falls back to IDLE so an
   // abandoned request can never wedge the FSM.
   always_comb begin
      w_owner     = OWN_NONE;
      w_nextState = IDLE;
      if (w_cpuStarved) begin
         w_owner = OWN_CPU;
      end else if (bus.vga_req) begin
         w_owner = OWN_VGA;
      end else if (bus.cpu_req && (r_state == IDLE)) begin
         w_owner = OWN_CPU;
      end
      if (w_owner == OWN_CPU) begin
         w_nextState = CPU_ACK;
      end
   end

   assign w_cpuGnt   = (w_owner == OWN_CPU);
   assign w_vgaGnt   = (w_owner == OWN_VGA);
   assign w_cpuStall = bus.cpu_req && (r_state == IDLE) && !w_cpuGnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_waitCnt <= '0;
      end else if (w_cpuGnt) begin
         r_waitCnt <= '0;
      end else if (w_cpuStall && (r_waitCnt != MAX_WAIT)) begin
         r_waitCnt <= r_waitCnt + 1'b1;
      end
   end

   always_comb begin
      w_memEn    = 1'b0;
      w_memWe    = '0;
      w_memAddr  = '0;
      w_memWdata = '0;
      unique case (w_owner)
         OWN_VGA: begin
            w_memEn   = 1'b1;
            w_memAddr = bus.vga_addr;
         end
         OWN_CPU: begin
            w_memEn    = 1'b1;
            w_memAddr  = bus.cpu_addr;
            w_memWdata = bus.cpu_wdata;
            w_memWe    = bus.cpu_we ? bus.cpu_wstrb : '0;
         end
         default: begin
         end
      endcase
   end

   assign bus.mem_en    = w_memEn;
   assign bus.mem_we    = w_memWe;
   assign bus.mem_addr  = w_memAddr;
   assign bus.mem_wdata = w_memWdata;
   assign bus.vga_gnt   = w_vgaGnt;

   // The memory returns data one cycle after mem_en, so the response
   // flags only need to remember who owned the port last cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vgaRvalid <= 1'b0;
         r_cpuAck    <= 1'b0;
         r_cpuRead   <= 1'b0;
      end else begin
         r_vgaRvalid <= w_vgaGnt;
         r_cpuAck    <= w_cpuGnt;
         r_cpuRead   <= w_cpuGnt && !bus.cpu_we;
      end
   end

   assign bus.vga_rvalid = r_vgaRvalid;
   assign bus.vga_rdata  = r_vgaRvalid ? bus.mem_rdata : '0;
   assign bus.cpu_ack    = r_cpuAck;
   assign bus.cpu_rdata  = (r_cpuAck && r_cpuRead) ? bus.mem_rdata : '0;

`ifdef FB_ARB_STATS_EN
   fb_arb_stats u_stats (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_vgaGnt      (w_vgaGnt),
      .i_cpuStall    (w_cpuStall),
      .o_vgaCnt      (stat_vga_cnt),
      .o_cpuStallCnt (stat_cpu_stall_cnt)
   );
`else
   assign stat_vga_cnt       = '0;
   assign stat_cpu_stall_cnt = '0;
`endif

endmodule

// File: doc/framebuffer_arbiter.md
# framebuffer_arbiter

Arbitrates the single-port VGA framebuffer BRAM between two requesters: the VGA scanout line fetcher (read-only, high priority) and the CPU data bus (read/write, low priority, starvation-protected). Sits inside Grande_Risco_5_SOC between the bus decoder's framebuffer window, the VGA timing/fetch block and the framebuffer memory. Issues at most one memory access per cycle and returns read data with fixed one-cycle latency.

## Interface
- ADDR_WIDTH, 17: framebuffer word address width.
- DATA_WIDTH, 32: memory data width; a multiple of 8.
- CPU_MAX_WAIT, 8: consecutive CPU-blocked cycles after which the CPU beats VGA; range 1..255.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- vga_req  in  1  VGA fetch wants a read this cycle.
- vga_addr  in  ADDR_WIDTH  VGA read address.
- vga_gnt  out  1  combinational; VGA access issued this cycle.
- vga_rvalid  out  1  registered; vga_rdata valid.
- vga_rdata  out  DATA_WIDTH  VGA read data.
- cpu_req  in  1  CPU access request, held until cpu_ack.
- cpu_we  in  1  1 = write.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_wstrb  in  DATA_WIDTH/8  byte enables for writes.
- cpu_ack  out  1  registered single-cycle completion pulse.
- cpu_rdata  out  DATA_WIDTH  valid with cpu_ack on reads; 0 on writes.
- mem_en  out  1  combinational memory enable.
- mem_we  out  DATA_WIDTH/8  combinational byte write enables.
- mem_addr  out  ADDR_WIDTH  combinational memory address.
- mem_wdata  out  DATA_WIDTH  combinational write data.
- mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after mem_en.
- stat_vga_cnt  out  32  VGA grant count (see Configuration).
- stat_cpu_stall_cnt  out  32  CPU blocked-cycle count (see Configuration).

## Operation
- FSM states: IDLE, CPU_ACK. CPU_ACK lasts exactly one cycle, then returns to IDLE.
- Arbitration each cycle, in priority order:
  - Starved CPU: cpu_req, state IDLE and wait_cnt == CPU_MAX_WAIT → CPU.
  - Otherwise vga_req → VGA.
  - Otherwise cpu_req in IDLE → CPU.
- CPU is never granted in CPU_ACK, so a held cpu_req is not issued twice.
- wait_cnt (8 bit):
  - Increments, saturating at CPU_MAX_WAIT, in each IDLE cycle with cpu_req high and CPU not granted.
  - Clears on CPU grant.
  - Holds when cpu_req is low.
- VGA grant: mem_en=1, mem_we=0, mem_addr=vga_addr. Next cycle vga_rvalid=1, vga_rdata=mem_rdata.
- CPU grant: mem_en=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=cpu_we ? cpu_wstrb : 0. State goes to CPU_ACK; next cycle cpu_ack=1, cpu_rdata=mem_rdata for reads, 0 for writes.
- No grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- vga_gnt and CPU grant are mutually exclusive. When vga_gnt=0, the VGA fetcher holds its address.

## Timing
- Reset drives all registered outputs to 0, state to IDLE, wait_cnt to 0 and stats to 0. Combinational outputs follow the idle rule.
- Read latency is 1 cycle for both requesters. CPU request-to-ack is 1 cycle minimum; worst case CPU_MAX_WAIT+1 cycles under continuous vga_req.
- Maximum CPU throughput is one access per 2 cycles.
- Reset asserted mid-access: the pending vga_rvalid or cpu_ack is dropped and never issued. The CPU reissues after reset.
- cpu_req falling before ack is illegal. Behaviour is undefined, but the FSM must still return to IDLE.

## Configuration
- FB_ARB_STATS_EN defined:
  - stat_vga_cnt increments on every vga_gnt.
  - stat_cpu_stall_cnt increments on every wait_cnt increment condition.
  - Both are 32-bit wrapping counters, cleared by reset.
- Not defined: both outputs tied to 0 and no counter flops are generated.

## Structure
- Package fb_arb_pkg holds the state enum (IDLE, CPU_ACK), the owner enum (OWN_NONE, OWN_VGA, OWN_CPU) and the default wait limit constant.
- Optional sub-module fb_arb_stats holds the two counters, instantiated only under FB_ARB_STATS_EN.

## Test plan
- Idle CPU read, addr 0x00010, mem holds 0xDEADBEEF → mem_en the same cycle; cpu_ack and cpu_rdata=0xDEADBEEF one cycle later; vga_gnt stays 0.
- CPU write, wdata 0x11223344, wstrb 4'b0101 → mem_we=4'b0101 for one cycle; ack next cycle with cpu_rdata=0; a readback returns the merged bytes.
- Continuous vga_req, cpu_req asserted at cycle 0, CPU_MAX_WAIT=8 → vga_gnt for 8 cycles; CPU granted at cycle 8 with vga_gnt=0; VGA resumes at cycle 9; wait_cnt cleared.
- vga_req and cpu_req rise together, wait_cnt=0 → VGA wins; CPU granted only after vga_req drops or at starvation.
- cpu_req held high across ack → second access issued no earlier than the cycle after cpu_ack; no double grant.
- rst_n pulsed low in the cycle after a CPU grant → no cpu_ack; all outputs 0; with FB_ARB_STATS_EN, both stat counters read 0.
